serial_adder16: RTL and testbench

//  Bit-serial ripple adder: the additive counterpart of the 16-bit parallel borrow subtractor.

---
 rtl/adder_pkg.sv | 14 +
 rtl/serial_adder16_full_add1.sv | 22 ++
 rtl/serial_adder16.sv | 114 +++++++++++
 tb/tb_serial_adder16.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Package: adder_pkg
// Shared definitions for the bit-serial adder: default operand width and
// the FSM state encoding used by serial_adder16.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder16_full_add1.sv
// Module: full_add1
// Purpose: single-bit combinational full adder, the only arithmetic cell of
//          the bit-serial adder. Port order (cout,sum,a,b,cin) matches the
//          companion full_sub1 cell of the subtractor.
// Ports:
//   cout  out  carry out
//   sum   out  sum bit
//   a     in   operand A bit
//   b     in   operand B bit
//   cin   in   carry in
module full_add1 (
  output logic cout,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder16.sv
// Module: serial_adder16
// Purpose: bit-serial ripple adder. Adds two WIDTH-bit operands plus a
//          carry-in, one bit per clock, LSB first, through one full_add1 cell.
//          A start/busy/done handshake talks to the sequencing logic.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, accepted only when busy=0
//   in0    in   operand A, sampled on accepted start
//   in1    in   operand B, sampled on accepted start
//   cin    in   carry-in, sampled on accepted start
//   busy   out  high while the addition is in progress
//   done   out  one-cycle pulse when sum/cout/ovf become valid
//   sum    out  result, stable from done until the next accepted start
//   cout   out  carry out of the MSB
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
module serial_adder16
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             bit_sum;
  logic             bit_cout;

  full_add1 u_fa (
    .cout (bit_cout),
    .sum  (bit_sum),
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry)
  );

  // Control FSM and datapath. The result bit enters at the sum MSB so that
  // after WIDTH shifts bit 0 of the result has reached sum[0]. On the last
  // bit the carry register still holds the carry into the MSB, which is what
  // the signed overflow needs alongside the MSB carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= in0;
            b_reg <= in1;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= S_ADD;
          end else begin
            state <= S_IDLE;
          end
        end

        S_ADD: begin
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          sum   <= {bit_sum, sum[WIDTH-1:1]};
          carry <= bit_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            cout  <= bit_cout;
            ovf   <= carry ^ bit_cout;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder16.sv
// Testbench: tb_serial_adder16
// Randomized and directed checking of serial_adder16 against an arithmetic
// reference model (plain integer addition and a signed range test).
module tb_serial_adder16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total;
  int bad;

  serial_adder16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in0   (in0),
    .in1   (in1),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one addition. Must be entered just after a falling edge; start is
  // raised for one cycle, the operands are scrambled right after the
  // accepting edge, and the task returns at the falling edge where done is
  // seen. Latency counts rising edges from raising start to seeing done.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic c, input string tag);
    logic [16:0] exp_full;
    int          s;
    logic        exp_ovf;
    int          lat;
    exp_full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    s        = int'($signed(a)) + int'($signed(b)) + int'(c);
    exp_ovf  = (s > 32767) || (s < -32768);
    in0   = a;
    in1   = b;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in0   = 16'($urandom);
    in1   = 16'($urandom);
    cin   = 1'($urandom);
    lat   = 1;
    checkOutput({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 32'd17);
    checkOutput({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_full[15:0]});
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_full[16]});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    int first_lat;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    in0   = '0;
    in1   = '0;
    cin   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum}, 32'd0);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);

    // Directed cases with explicit expected results
    @(negedge clk);
    applyStimulus(16'h1234, 16'h4321, 1'b0, "d1");
    checkOutput("d1_sum_const", {16'd0, sum}, 32'h5555);
    @(negedge clk);
    checkOutput("d1_done_width", {31'd0, done}, 32'd0);

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, "d2");
    checkOutput("d2_sum_const", {15'd0, cout, sum}, 32'h10000);
    @(negedge clk);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, "d3");
    checkOutput("d3_ovf_const", {15'd0, ovf, sum}, 32'h18000);
    @(negedge clk);
    applyStimulus(16'h8000, 16'h8000, 1'b0, "d3b");
    checkOutput("d3b_const", {14'd0, ovf, cout, sum}, 32'h30000);
    @(negedge clk);

    // Back-to-back: second start raised during the done cycle
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, "d4");
    checkOutput("d4_const", {15'd0, cout, sum}, 32'h1FFFF);
    applyStimulus(16'hA5A5, 16'h5A5B, 1'b1, "d4_b2b");
    @(negedge clk);
    checkOutput("d4_done_width", {31'd0, done}, 32'd0);

    // Start pulses while busy must be ignored
    in0 = 16'h1111;
    in1 = 16'h2222;
    cin = 1'b0;
    start = 1'b1;
    done_cnt  = 0;
    first_lat = 0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      start = (e == 3 || e == 8);
      in0   = 16'($urandom);
      in1   = 16'($urandom);
      cin   = 1'($urandom);
      if (done) begin
        done_cnt++;
        if (first_lat == 0) first_lat = e;
      end
    end
    start = 1'b0;
    checkOutput("busy_start_done_cnt", done_cnt, 32'd1);
    checkOutput("busy_start_latency", first_lat, 32'd17);
    checkOutput("busy_start_sum", {15'd0, cout, sum}, 32'h3333);

    // Reset in the middle of an operation
    in0 = 16'hFFFF;
    in1 = 16'h0000;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_sum", {16'd0, sum}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    done_cnt = 0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    checkOutput("midrst_no_done", done_cnt, 32'd0);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), "rnd");
      @(negedge clk);
      checkOutput("rnd_done_width", {31'd0, done}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
